// File: rtl/glyph_row_if.sv
// glyph_row_if: start/selection controls and the row valid/ready link of the
// glyph row streamer, plus its status outputs.
//   master: the control side. It drives start/glyph_sel/mirror/abort and row_ready.
//   slave : the streamer. It drives busy, the row beat fields, done, sel_err and frame_cnt.
interface glyph_row_if #(
  parameter int GLYPH_W = 25,
  parameter int GLYPH_H = 25,
  parameter int SEL_W   = 5
);
  localparam int IDX_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;

  logic               start;
  logic [SEL_W-1:0]   glyph_sel;
  logic               mirror;
  logic               abort;
  logic               busy;
  logic               row_valid;
  logic               row_ready;
  logic [GLYPH_W-1:0] row_data;
  logic [IDX_W-1:0]   row_idx;
  logic               row_last;
  logic               done;
  logic               sel_err;
  logic [7:0]         frame_cnt;

  modport master (
    output start, glyph_sel, mirror, abort, row_ready,
    input  busy, row_valid, row_data, row_idx, row_last, done, sel_err, frame_cnt
  );

  modport slave (
    input  start, glyph_sel, mirror, abort, row_ready,
    output busy, row_valid, row_data, row_idx, row_last, done, sel_err, frame_cnt
  );
endinterface

// File: rtl/glyph_row_streamer.sv
// glyph_row_streamer: constant glyph bitmap store plus a row streamer for the
// display path. Pixel value 0 is lit and 1 is dark. Each row is emitted SCALE
// times, and the row can be bit-reversed (mirror) on the way out.
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   io_row  : glyph_row_if.slave. Carries the start/select/abort controls,
//             the row valid/ready beat and the done/sel_err/frame_cnt status.
//
// state    | meaning
// S_IDLE   | waiting for start, busy=0
// S_STREAM | presenting row beats, row_valid=1
// S_DONE   | single cycle after the final beat, done=1 unless aborted
module glyph_row_streamer #(
  parameter int GLYPH_W    = 25,
  parameter int GLYPH_H    = 25,
  parameter int NUM_GLYPHS = 16,
  parameter int SCALE      = 1,
  parameter int SEL_W      = $clog2(NUM_GLYPHS) + 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  glyph_row_if.slave io_row
);

  localparam int ROW_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int REP_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int GI_W  = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1;
  localparam logic [GLYPH_W-1:0] DARK = '1;
  localparam logic [GLYPH_W-1:0] ONE  = GLYPH_W'(1);
  localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(GLYPH_H - 1);
  localparam logic [REP_W-1:0]   LAST_REP = REP_W'(SCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  // Glyph art. Digits share a three-row dark border top and bottom. Glyph 2
  // carries the fixed two-column pattern of the display bring-up set. The other
  // digits carry a single marker column. 10 is an X, 11 is a ring (O), and
  // 12 and above are blank.
  function automatic logic [GLYPH_W-1:0] glyph_row(input int g, input int r);
    logic [GLYPH_W-1:0] row;
    row = DARK;
    if (g == 10) begin
      for (int c = 0; c < GLYPH_W; c++)
        if (c == r || c == GLYPH_W - 1 - r) row = row & ~(ONE << c);
    end else if (g == 11) begin
      for (int c = 0; c < GLYPH_W; c++)
        if (((r == 3 || r == GLYPH_H - 4) && c >= 3 && c <= GLYPH_W - 4) ||
            ((c == 3 || c == GLYPH_W - 4) && r >= 3 && r <= GLYPH_H - 4))
          row = row & ~(ONE << c);
    end else if (g < 10 && r >= 3 && r <= GLYPH_H - 4) begin
      if (g == 2) row = row & ~(ONE << (GLYPH_W - 2)) & ~(ONE << (GLYPH_W - 6));
      else        row = row & ~(ONE << ((2 * g + 1) % GLYPH_W));
    end
    return row;
  endfunction

  logic [GLYPH_W-1:0] w_rom [NUM_GLYPHS][GLYPH_H];

  for (genvar g = 0; g < NUM_GLYPHS; g++) begin : g_glyph
    for (genvar r = 0; r < GLYPH_H; r++) begin : g_row
      assign w_rom[g][r] = glyph_row(g, r);
    end
  end

  state_t             r_state, w_state_nxt;
  logic [GI_W-1:0]    r_glyph, w_glyph_nxt;
  logic               r_blank, w_blank_nxt;
  logic               r_mirror, w_mirror_nxt;
  logic [ROW_W-1:0]   r_row, w_row_nxt;
  logic [REP_W-1:0]   r_rep, w_rep_nxt;
  logic [GLYPH_W-1:0] r_data, w_data_nxt;
  logic               r_last, w_last_nxt;
  logic               r_sel_err, w_sel_err_nxt;
  logic [7:0]         r_frame_cnt, w_cnt_nxt;
  logic               w_done;
  logic               w_load;
  logic               w_sel_oor;
  logic [GLYPH_W-1:0] w_rom_row;

  assign w_sel_oor = (io_row.glyph_sel >= SEL_W'(NUM_GLYPHS));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_glyph     <= '0;
      r_blank     <= 1'b0;
      r_mirror    <= 1'b0;
      r_row       <= '0;
      r_rep       <= '0;
      r_data      <= DARK;
      r_last      <= 1'b0;
      r_sel_err   <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_glyph     <= w_glyph_nxt;
      r_blank     <= w_blank_nxt;
      r_mirror    <= w_mirror_nxt;
      r_row       <= w_row_nxt;
      r_rep       <= w_rep_nxt;
      r_data      <= w_data_nxt;
      r_last      <= w_last_nxt;
      r_sel_err   <= w_sel_err_nxt;
      r_frame_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_glyph_nxt   = r_glyph;
    w_blank_nxt   = r_blank;
    w_mirror_nxt  = r_mirror;
    w_row_nxt     = r_row;
    w_rep_nxt     = r_rep;
    w_data_nxt    = r_data;
    w_last_nxt    = r_last;
    w_sel_err_nxt = 1'b0;
    w_cnt_nxt     = r_frame_cnt;
    w_done        = 1'b0;
    w_load        = 1'b0;
    w_rom_row     = DARK;

    case (r_state)
      S_IDLE: begin
        // A start wins over a coincident abort here, because abort is only looked at
        // once a frame is running.
        if (io_row.start) begin
          w_state_nxt   = S_STREAM;
          w_glyph_nxt   = io_row.glyph_sel[GI_W-1:0];
          w_blank_nxt   = w_sel_oor;
          w_mirror_nxt  = io_row.mirror;
          w_row_nxt     = '0;
          w_rep_nxt     = '0;
          w_sel_err_nxt = w_sel_oor;
          w_load        = 1'b1;
        end
      end
      S_STREAM: begin
        // Abort is checked before the handshake, so it cancels a beat that would
        // otherwise transfer in the same cycle.
        if (io_row.abort || (io_row.row_ready && r_last)) begin
          w_state_nxt = io_row.abort ? S_IDLE : S_DONE;
          w_data_nxt  = DARK;
          w_last_nxt  = 1'b0;
          w_row_nxt   = '0;
          w_rep_nxt   = '0;
        end else if (io_row.row_ready) begin
          w_load = 1'b1;
          if (r_rep == LAST_REP) begin
            w_rep_nxt = '0;
            w_row_nxt = r_row + 1'b1;
          end else begin
            w_rep_nxt = r_rep + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        if (!io_row.abort) begin
          w_done    = 1'b1;
          w_cnt_nxt = r_frame_cnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // The ROM is read with the next-beat coordinates, so the output register holds
    // the row that goes with the beat it presents.
    if (w_load) begin
      w_rom_row  = w_blank_nxt ? DARK : w_rom[w_glyph_nxt][w_row_nxt];
      w_data_nxt = w_mirror_nxt ? {<<{w_rom_row}} : w_rom_row;
      w_last_nxt = (w_row_nxt == LAST_ROW) && (w_rep_nxt == LAST_REP);
    end
  end

  assign io_row.busy      = (r_state != S_IDLE);
  assign io_row.row_valid = (r_state == S_STREAM);
  assign io_row.row_data  = r_data;
  assign io_row.row_idx   = r_row;
  assign io_row.row_last  = r_last;
  assign io_row.done      = w_done;
  assign io_row.sel_err   = r_sel_err;
  assign io_row.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_glyph_row_streamer.sv
// tb_glyph_row_streamer: drives a SCALE=1 and a SCALE=2 streamer from directed
// and randomized frames. Each frame is checked beat by beat against an expected
// beat list, which is built from the glyph pixel rules.
module tb_glyph_row_streamer;
  localparam int W  = 25;
  localparam int H  = 25;
  localparam int NG = 16;
  localparam int SW = 5;
  localparam logic [W-1:0] ONE = W'(1);

  typedef struct {
    logic [W-1:0] d;
    int           idx;
    bit           last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  glyph_row_if #(.GLYPH_W(W), .GLYPH_H(H), .SEL_W(SW)) ifa ();
  glyph_row_if #(.GLYPH_W(W), .GLYPH_H(H), .SEL_W(SW)) ifb ();

  glyph_row_streamer #(.GLYPH_W(W), .GLYPH_H(H), .NUM_GLYPHS(NG), .SCALE(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .io_row(ifa));
  glyph_row_streamer #(.GLYPH_W(W), .GLYPH_H(H), .NUM_GLYPHS(NG), .SCALE(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .io_row(ifb));

  logic          start = 1'b0, mirror = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [SW-1:0] gsel = '0;
  int            which = 0;
  int            n_cmp = 0, n_bad = 0;
  int            exp_cnt [2];

  assign ifa.start     = start & (which == 0);
  assign ifb.start     = start & (which == 1);
  assign ifa.abort     = abort & (which == 0);
  assign ifb.abort     = abort & (which == 1);
  assign ifa.glyph_sel = gsel;
  assign ifb.glyph_sel = gsel;
  assign ifa.mirror    = mirror;
  assign ifb.mirror    = mirror;
  assign ifa.row_ready = ready;
  assign ifb.row_ready = ready;

  logic         o_busy, o_valid, o_last, o_done, o_serr;
  logic [W-1:0] o_data;
  logic [4:0]   o_idx;
  logic [7:0]   o_cnt;

  always_comb begin
    if (which == 0) begin
      o_busy = ifa.busy; o_valid = ifa.row_valid; o_last = ifa.row_last; o_done = ifa.done;
      o_serr = ifa.sel_err; o_data = ifa.row_data; o_idx = ifa.row_idx; o_cnt = ifa.frame_cnt;
    end else begin
      o_busy = ifb.busy; o_valid = ifb.row_valid; o_last = ifb.row_last; o_done = ifb.done;
      o_serr = ifb.sel_err; o_data = ifb.row_data; o_idx = ifb.row_idx; o_cnt = ifb.frame_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel-level description of each glyph. A bit value of 0 means the pixel is lit.
  function automatic logic [W-1:0] model_row(input int g, input int r, input bit mir);
    logic [W-1:0] row;
    logic [W-1:0] rev;
    bit lit;
    row = '1;
    if (g == 2) begin
      if (r >= 3 && r <= 21) row = 25'h177FFFF;
    end else begin
      for (int c = 0; c < W; c++) begin
        lit = 1'b0;
        if (g == 10)      lit = (c == r) || (c == 24 - r);
        else if (g == 11) lit = ((r == 3 || r == 21) && c >= 3 && c <= 21) ||
                                ((c == 3 || c == 21) && r >= 3 && r <= 21);
        else if (g < 10)  lit = (r >= 3 && r <= 21 && c == 2 * g + 1);
        if (lit) row = row & ~(ONE << c);
      end
    end
    rev = '1;
    for (int c = 0; c < W; c++)
      if (row[c] == 1'b0) rev = rev & ~(ONE << (W - 1 - c));
    return mir ? rev : row;
  endfunction

  // abort_at: the beat index at which abort is raised. H*scale means the DONE cycle,
  // and -1 means no abort.
  task automatic run_frame(input int dut, input int g, input bit mir, input int abort_at,
                           input int restart_at, input bit abort_with_start,
                           input int ready_pct, input int hold_at);
    beat_t q[$];
    int scale, total, b, cyc, hold;
    bit oor;
    scale = (dut == 0) ? 1 : 2;
    oor   = (g >= NG);
    for (int r = 0; r < H; r++)
      for (int k = 0; k < scale; k++)
        q.push_back('{oor ? '1 : model_row(g, r, mir), r, (r == H - 1) && (k == scale - 1)});
    total = H * scale;
    which = dut;
    #1;
    check("idle_busy", o_busy, 0);
    gsel = g[SW-1:0]; mirror = mir; start = 1'b1; abort = abort_with_start;
    ready = 1'(($urandom_range(1, 100) <= ready_pct));
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    gsel = SW'($urandom); mirror = 1'($urandom);
    check("sel_err_pulse", o_serr, oor);
    check("busy_after_start", o_busy, 1);
    b = 0; cyc = 0; hold = 0;
    while (b < total) begin
      if (cyc == 1) check("sel_err_clear", o_serr, 0);
      check("row_valid", o_valid, 1);
      check("row_data", o_data, q[b].d);
      check("row_idx", o_idx, q[b].idx);
      check("row_last", o_last, q[b].last);
      if (b == abort_at) begin
        abort = 1'b1; ready = 1'($urandom);
        @(posedge clk); #1;
        abort = 1'b0; ready = 1'b0;
        check("abort_valid", o_valid, 0);
        check("abort_busy", o_busy, 0);
        check("abort_done", o_done, 0);
        @(posedge clk); #1;
        check("abort_no_done", o_done, 0);
        check("abort_cnt", o_cnt, exp_cnt[dut]);
        return;
      end
      if (b == restart_at) start = 1'b1;
      if (b == hold_at && hold < 5) begin
        ready = 1'b0; hold++;
      end else begin
        ready = 1'(($urandom_range(1, 100) <= ready_pct));
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (ready) b++;
      cyc++;
      if (cyc > 2000) begin
        n_cmp++; n_bad++;
        $error("FAIL frame_timeout observed=beat %0d expected=%0d beats", b, total);
        return;
      end
    end
    ready = 1'b0;
    if (abort_at == total) begin
      abort = 1'b1; #1;
      check("abort_in_done", o_done, 0);
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_done_busy", o_busy, 0);
      check("abort_done_cnt", o_cnt, exp_cnt[dut]);
      return;
    end
    check("done_pulse", o_done, 1);
    check("done_valid", o_valid, 0);
    check("done_data", o_data, 32'h1FFFFFF);
    check("done_busy", o_busy, 1);
    check("done_cnt_pre", o_cnt, exp_cnt[dut]);
    @(posedge clk); #1;
    exp_cnt[dut] = (exp_cnt[dut] + 1) % 256;
    check("done_clear", o_done, 0);
    check("idle_after_done", o_busy, 0);
    check("frame_cnt", o_cnt, exp_cnt[dut]);
  endtask

  initial begin
    int g, ab, rs;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_data", o_data, 32'h1FFFFFF);
    check("rst_idx", o_idx, 0);
    check("rst_last", o_last, 0);
    check("rst_done", o_done, 0);
    check("rst_sel_err", o_serr, 0);
    check("rst_cnt", o_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 2, 1'b0, -1, -1, 1'b0, 100, -1);
    run_frame(0, 2, 1'b1, -1, -1, 1'b0, 100, -1);
    run_frame(0, 2, 1'b0, -1, -1, 1'b0, 100, 7);
    run_frame(0, 11, 1'b0, -1, 4, 1'b0, 70, -1);
    run_frame(0, 10, 1'b1, -1, -1, 1'b1, 80, -1);
    run_frame(0, 20, 1'b0, -1, -1, 1'b0, 100, -1);
    run_frame(0, 20, 1'b0, 5, -1, 1'b0, 100, -1);
    run_frame(0, 3, 1'b0, H, -1, 1'b0, 90, -1);

    which = 0;
    gsel = 5'd2; mirror = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_idx", o_idx, 10);
    rst_n = 1'b0; #1;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    check("midrst_valid", o_valid, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_data", o_data, 32'h1FFFFFF);
    check("midrst_cnt", o_cnt, 0);
    check("midrst_idx", o_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_valid", o_valid, 0);
    ready = 1'b0;

    run_frame(1, 2, 1'b0, -1, -1, 1'b0, 100, -1);
    run_frame(1, 11, 1'b1, -1, 9, 1'b0, 60, 13);
    run_frame(1, 25, 1'b0, 30, -1, 1'b0, 75, -1);

    for (int i = 0; i < 30; i++) begin
      g  = $urandom_range(0, 31);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, H) : -1;
      rs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
      run_frame(0, g, 1'($urandom), ab, rs, 1'($urandom), $urandom_range(40, 100), -1);
    end
    for (int i = 0; i < 6; i++) begin
      g  = $urandom_range(0, 31);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * H) : -1;
      run_frame(1, g, 1'($urandom), ab, -1, 1'b0, $urandom_range(50, 100), -1);
    end

    for (int i = 0; i < 258; i++)
      run_frame(0, $urandom_range(0, 15), 1'($urandom), -1, -1, 1'b0, 100, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
